alu_share_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one combinational 32-bit ALU (8-opcode: add, sub, inc, dec, pass, not, or, and) among NUM_REQ requesters. Each requester presents operands and an opcode with a valid/ready handshake. The block grants one requester, drives the ALU for one cycle with enable high, and registers the result. It then returns the result to the granted requester over a valid/ready response channel. It sits between the execution clients and the ALU instance, and owns all of the ALU's input ports.

---
 rtl/alu_share_arbiter.sv | 112 +++++++++++
 tb/tb_alu_share_arbiter.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter that shares one combinational ALU among NUM_REQ requesters.
// One transaction in flight: accept in IDLE, drive the ALU in EXEC, return the result in RESP.
module alu_share_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_REQ-1:0]       req_valid,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic [NUM_REQ*WIDTH-1:0] req_a,
    input  logic [NUM_REQ*WIDTH-1:0] req_b,
    input  logic [NUM_REQ*3-1:0]     req_op,
    output logic [NUM_REQ-1:0]       resp_valid,
    input  logic [NUM_REQ-1:0]       resp_ready,
    output logic [WIDTH-1:0]         resp_result,
    output logic [WIDTH-1:0]         alu_a,
    output logic [WIDTH-1:0]         alu_b,
    output logic [2:0]               alu_opcode,
    output logic                     alu_enable,
    input  logic [WIDTH-1:0]         alu_result,
    output logic                     busy,
    output logic [15:0]              op_count
);

    // state  | meaning
    // S_IDLE | waiting for a request; req_ready offered to the round-robin winner
    // S_EXEC | ALU driven from latched operands, result captured at end of cycle
    // S_RESP | result presented to the granted requester until it is consumed
    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {S_IDLE, S_EXEC, S_RESP} state_t;

    state_t           state;
    logic [PW-1:0]    rr_ptr;
    logic [PW-1:0]    gnt_q;
    logic [PW-1:0]    grant;
    logic [PW:0]      idx;
    logic             found;
    logic             armed;
    logic             req_hs;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] res_q;
    logic [2:0]       op_q;

    always_comb begin
        found = 1'b0;
        grant = '0;
        idx   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = {1'b0, rr_ptr} + (PW+1)'(i);
            if (idx >= (PW+1)'(NUM_REQ))
                idx = idx - (PW+1)'(NUM_REQ);
            if (!found && req_valid[idx[PW-1:0]]) begin
                found = 1'b1;
                grant = idx[PW-1:0];
            end
        end
    end

    // armed keeps req_ready low through reset and the first cycle after release
    assign req_ready   = (state == S_IDLE && armed && found) ? (NUM_REQ'(1) << grant) : '0;
    assign req_hs      = |(req_valid & req_ready);
    assign resp_valid  = (state == S_RESP) ? (NUM_REQ'(1) << gnt_q) : '0;
    assign resp_result = res_q;
    assign alu_a       = a_q;
    assign alu_b       = b_q;
    assign alu_opcode  = op_q;
    assign alu_enable  = (state == S_EXEC);
    assign busy        = (state != S_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            armed    <= 1'b0;
            rr_ptr   <= '0;
            gnt_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            op_q     <= '0;
            res_q    <= '0;
            op_count <= '0;
        end else begin
            armed <= 1'b1;
            case (state)
                S_IDLE: begin
                    if (req_hs) begin
                        a_q   <= req_a[grant*WIDTH +: WIDTH];
                        b_q   <= req_b[grant*WIDTH +: WIDTH];
                        op_q  <= req_op[grant*3 +: 3];
                        gnt_q <= grant;
                        state <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    res_q <= alu_result;
                    state <= S_RESP;
                end
                S_RESP: begin
                    if (resp_ready[gnt_q]) begin
                        op_count <= op_count + 16'd1;
                        rr_ptr   <= (gnt_q == PW'(NUM_REQ - 1)) ? '0 : gnt_q + PW'(1);
                        state    <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Self-checking bench for alu_share_arbiter: behavioural ALU, transaction-level
// round-robin model, directed cases plus randomized traffic.
module tb_alu_share_arbiter;

    localparam int N = 4;
    localparam int W = 32;

    logic            clk;
    logic            rst_n;
    logic [N-1:0]    req_valid;
    logic [N-1:0]    req_ready;
    logic [N*W-1:0]  req_a;
    logic [N*W-1:0]  req_b;
    logic [N*3-1:0]  req_op;
    logic [N-1:0]    resp_valid;
    logic [N-1:0]    resp_ready;
    logic [W-1:0]    resp_result;
    logic [W-1:0]    alu_a;
    logic [W-1:0]    alu_b;
    logic [2:0]      alu_opcode;
    logic            alu_enable;
    logic [W-1:0]    alu_result;
    logic            busy;
    logic [15:0]     op_count;

    logic [W-1:0]    a_v [N];
    logic [W-1:0]    b_v [N];
    logic [2:0]      op_v [N];

    int              n_checks = 0;
    int              n_fail = 0;
    int              model_rr = 0;
    logic [15:0]     model_cnt = 16'd0;
    logic [W-1:0]    last_res;

    alu_share_arbiter #(.NUM_REQ(N), .WIDTH(W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_a       (req_a),
        .req_b       (req_b),
        .req_op      (req_op),
        .resp_valid  (resp_valid),
        .resp_ready  (resp_ready),
        .resp_result (resp_result),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_opcode  (alu_opcode),
        .alu_enable  (alu_enable),
        .alu_result  (alu_result),
        .busy        (busy),
        .op_count    (op_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar gi = 0; gi < N; gi++) begin : g_pack
        assign req_a[gi*W +: W] = a_v[gi];
        assign req_b[gi*3*0 + gi*W +: W] = b_v[gi];
        assign req_op[gi*3 +: 3] = op_v[gi];
    end

    function automatic logic [W-1:0] alu_ref(input logic [W-1:0] a, input logic [W-1:0] b,
                                             input logic [2:0] op);
        case (op)
            3'd0:    return a + b;
            3'd1:    return a - b;
            3'd2:    return a + 1;
            3'd3:    return a - 1;
            3'd4:    return a;
            3'd5:    return ~a;
            3'd6:    return a | b;
            default: return a & b;
        endcase
    endfunction

    // The ALU only produces a meaningful value while enabled
    always_comb alu_result = alu_enable ? alu_ref(alu_a, alu_b, alu_opcode) : 32'hDEAD_BEEF;

    function automatic logic [N-1:0] onehot(input int g);
        logic [N-1:0] m;
        m = '0;
        if (g >= 0 && g < N) m[g] = 1'b1;
        return m;
    endfunction

    function automatic int model_grant(input logic [N-1:0] vmask);
        for (int i = 0; i < N; i++) begin
            if (vmask[(model_rr + i) % N]) return (model_rr + i) % N;
        end
        return -1;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic scramble_ops();
        for (int i = 0; i < N; i++) begin
            a_v[i]  = $urandom;
            b_v[i]  = $urandom;
            op_v[i] = 3'($urandom_range(0, 7));
        end
    endtask

    task automatic do_reset();
        rst_n      = 1'b0;
        req_valid  = '0;
        resp_ready = '0;
        #3;
        rst_n      = 1'b1;
        model_rr   = 0;
        model_cnt  = 16'd0;
        tick();
    endtask

    // One full transaction starting in IDLE; bp = cycles of response backpressure
    task automatic run_txn(input logic [N-1:0] vmask, input int bp, output int g_obs);
        int           g;
        logic [W-1:0] expv;
        req_valid  = vmask;
        resp_ready = '0;
        #1;
        g     = model_grant(vmask);
        g_obs = -1;
        for (int i = 0; i < N; i++) if (req_ready[i]) g_obs = i;
        chk("req_ready_grant", 32'(req_ready), 32'(onehot(g)));
        chk("busy_idle", 32'(busy), 32'd0);
        chk("alu_en_idle", 32'(alu_enable), 32'd0);
        expv = alu_ref(a_v[g], b_v[g], op_v[g]);
        tick();
        chk("alu_en_exec", 32'(alu_enable), 32'd1);
        chk("req_ready_exec", 32'(req_ready), 32'd0);
        chk("alu_a", alu_a, a_v[g]);
        chk("alu_b", alu_b, b_v[g]);
        chk("alu_opcode", 32'(alu_opcode), 32'(op_v[g]));
        scramble_ops();
        tick();
        for (int k = 0; k <= bp; k++) begin
            chk("resp_valid", 32'(resp_valid), 32'(onehot(g)));
            chk("resp_result", resp_result, expv);
            chk("req_ready_resp", 32'(req_ready), 32'd0);
            chk("alu_en_resp", 32'(alu_enable), 32'd0);
            chk("busy_resp", 32'(busy), 32'd1);
            if (k < bp) begin
                resp_ready = N'($urandom) & ~onehot(g);
                tick();
            end
        end
        last_res   = resp_result;
        resp_ready = onehot(g) | N'($urandom);
        tick();
        resp_ready = '0;
        req_valid  = '0;
        model_cnt  = model_cnt + 16'd1;
        model_rr   = (g + 1) % N;
        #1;
        chk("op_count", 32'(op_count), 32'(model_cnt));
        chk("busy_after", 32'(busy), 32'd0);
        chk("resp_valid_after", 32'(resp_valid), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] op_tab [8];
        int           g;
        logic [N-1:0] m;
        op_tab = '{32'h8, 32'h2, 32'h6, 32'h4, 32'h5, 32'hFFFF_FFFA, 32'h7, 32'h1};

        rst_n      = 1'b0;
        req_valid  = '1;
        resp_ready = '0;
        scramble_ops();
        #2;
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_alu_en", 32'(alu_enable), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_op_count", 32'(op_count), 32'd0);
        chk("rst_alu_a", alu_a, 32'd0);
        chk("rst_alu_op", 32'(alu_opcode), 32'd0);
        #10;
        rst_n = 1'b1;
        #1;
        chk("req_ready_post_release", 32'(req_ready), 32'd0);
        req_valid = '0;
        tick();

        // single request
        a_v[0] = 32'd5; b_v[0] = 32'd3; op_v[0] = 3'd0;
        run_txn(4'b0001, 0, g);
        chk("single_grant", 32'(g), 32'd0);
        chk("single_result", last_res, 32'h8);
        chk("single_count", 32'(op_count), 32'd1);

        // all opcodes via requester 1
        for (int op = 0; op < 8; op++) begin
            a_v[1] = 32'd5; b_v[1] = 32'd3; op_v[1] = 3'(op);
            run_txn(4'b0010, 0, g);
            chk("opcode_result", last_res, op_tab[op]);
        end
        a_v[1] = 32'd0; b_v[1] = 32'd3; op_v[1] = 3'd3;
        run_txn(4'b0010, 0, g);
        chk("dec_zero", last_res, 32'hFFFF_FFFF);

        // contention right after reset
        do_reset();
        scramble_ops();
        run_txn(4'b0101, 0, g);
        chk("contend_first", 32'(g), 32'd0);
        run_txn(4'b0101, 0, g);
        chk("contend_second", 32'(g), 32'd2);

        // continuous valid rotation
        do_reset();
        for (int i = 0; i < 8; i++) begin
            run_txn(4'b1111, 0, g);
            chk("rotation", 32'(g), 32'(i % 4));
        end
        chk("rotation_count", 32'(op_count), 32'd8);

        // backpressure
        a_v[0] = 32'd5; b_v[0] = 32'd3; op_v[0] = 3'd0;
        run_txn(4'b0001, 5, g);
        chk("bp_result", last_res, 32'h8);

        // randomized traffic with idle gaps
        for (int t = 0; t < 40; t++) begin
            if ($urandom_range(0, 4) == 0) begin
                req_valid = '0;
                #1;
                chk("idle_ready", 32'(req_ready), 32'd0);
                tick();
                chk("idle_busy", 32'(busy), 32'd0);
                chk("idle_count", 32'(op_count), 32'(model_cnt));
            end
            scramble_ops();
            if ($urandom_range(0, 3) == 0) a_v[$urandom_range(0, N-1)] = 32'd0;
            m = N'($urandom);
            if (m == '0) m = onehot($urandom_range(0, N-1));
            run_txn(m, $urandom_range(0, 3), g);
        end

        // reset during EXEC
        a_v[3] = 32'd9; b_v[3] = 32'd4; op_v[3] = 3'd0;
        req_valid = 4'b1000;
        #1;
        chk("pre_abort_ready", 32'(req_ready), 32'(onehot(model_grant(4'b1000))));
        tick();
        chk("abort_in_exec", 32'(alu_enable), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("abort_alu_en", 32'(alu_enable), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_resp_valid", 32'(resp_valid), 32'd0);
        chk("abort_req_ready", 32'(req_ready), 32'd0);
        chk("abort_op_count", 32'(op_count), 32'd0);
        chk("abort_alu_a", alu_a, 32'd0);
        req_valid = '0;
        #2;
        rst_n     = 1'b1;
        model_rr  = 0;
        model_cnt = 16'd0;
        tick();
        tick();
        a_v[3] = 32'd5; b_v[3] = 32'd3; op_v[3] = 3'd7;
        run_txn(4'b1000, 0, g);
        chk("post_abort_grant", 32'(g), 32'd3);
        chk("post_abort_result", last_res, 32'h1);
        chk("post_abort_count", 32'(op_count), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
